// File: rtl/jk_bank_pkg.sv
// Shared definitions for the JK flag bank arbiter: op encodings and FSM states.
package jk_bank_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_t;

endpackage

// File: rtl/jk_cell.sv
// Single clocked JK flag with enable; {J,K} uses the same encoding as the bank ops.
module jk_cell
  import jk_bank_pkg::*;
(
  input  logic _clock,
  input  logic _reset,
  input  logic _J,
  input  logic _K,
  input  logic _E,
  output logic _Q,
  output logic _QNOT
);

  logic q_r;

  // Flag state: changes only on an enabled edge
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      q_r <= 1'b0;
    end else if (_E) begin
      case ({_J, _K})
        OP_SET:  q_r <= 1'b1;
        OP_CLR:  q_r <= 1'b0;
        OP_TGL:  q_r <= ~q_r;
        default: q_r <= q_r;
      endcase
    end else begin
      q_r <= q_r;
    end
  end

  assign _Q    = q_r;
  assign _QNOT = ~q_r;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing a bank of JK flags among NREQ requesters,
// one granted set/clear/toggle/hold command per cycle.
module jk_bank_arbiter
  import jk_bank_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IW    = $clog2(NBITS)
) (
  input  logic               _clock,
  input  logic               _reset,
  input  logic [NREQ-1:0]    _req,
  input  logic [2*NREQ-1:0]  _op,
  input  logic [IW*NREQ-1:0] _idx,
  input  logic               _flush,
  output logic [NREQ-1:0]    _gnt,
  output logic               _err,
  output logic               _busy,
  output logic [NBITS-1:0]   _Q,
  output logic [NBITS-1:0]   _QNOT
);

  localparam int              PW      = $clog2(NREQ);
  localparam logic [IW:0]     NBITS_L = (IW+1)'(NBITS);
  localparam logic [PW-1:0]   LAST_L  = PW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_L   = {{(NREQ-1){1'b0}}, 1'b1};

  state_t            state_r, state_nx_s;
  logic [PW-1:0]     ptr_r, ptr_nx_s;
  logic [NREQ-1:0]   gnt_r, gnt_nx_s;
  logic              err_r, err_nx_s;
  logic              busy_r;
  logic [1:0]        cmd_op_r, cmd_op_nx_s;
  logic [IW-1:0]     cmd_idx_r, cmd_idx_nx_s;

  logic [PW-1:0]     cand_s;
  logic [PW-1:0]     win_s;
  logic              win_vld_s;
  logic              hit_s;
  logic [1:0]        win_op_s;
  logic [IW-1:0]     win_idx_s;
  logic [NBITS-1:0]  cell_j_s, cell_k_s, cell_e_s;

  // Round-robin search: first requester at or after ptr wins
  always_comb begin
    cand_s    = '0;
    hit_s     = 1'b0;
    win_s     = '0;
    win_vld_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand_s    = PW'((int'(ptr_r) + i) % NREQ);
      hit_s     = !win_vld_s && _req[cand_s];
      win_s     = hit_s ? cand_s : win_s;
      win_vld_s = win_vld_s | _req[cand_s];
    end
  end

  // Select the winning requester's command fields
  always_comb begin
    win_op_s  = OP_HOLD;
    win_idx_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_op_s  = (win_s == PW'(i)) ? _op[2*i +: 2]   : win_op_s;
      win_idx_s = (win_s == PW'(i)) ? _idx[IW*i +: IW] : win_idx_s;
    end
  end

  // FSM next state; both states arbitrate so a held load streams back-to-back
  always_comb begin
    state_nx_s   = state_r;
    ptr_nx_s     = ptr_r;
    gnt_nx_s     = '0;
    err_nx_s     = 1'b0;
    cmd_op_nx_s  = cmd_op_r;
    cmd_idx_nx_s = cmd_idx_r;
    case (state_r)
      ST_IDLE, ST_APPLY: begin
        if (_flush) begin
          state_nx_s = ST_IDLE;
        end else if (win_vld_s) begin
          state_nx_s   = ST_APPLY;
          gnt_nx_s     = ONE_L << win_s;
          err_nx_s     = ({1'b0, win_idx_s} >= NBITS_L);
          ptr_nx_s     = (win_s == LAST_L) ? '0 : win_s + PW'(1);
          cmd_op_nx_s  = win_op_s;
          cmd_idx_nx_s = win_idx_s;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state_r   <= ST_IDLE;
      ptr_r     <= '0;
      gnt_r     <= '0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      cmd_op_r  <= OP_HOLD;
      cmd_idx_r <= '0;
    end else begin
      state_r   <= state_nx_s;
      ptr_r     <= ptr_nx_s;
      gnt_r     <= gnt_nx_s;
      err_r     <= err_nx_s;
      busy_r    <= (state_nx_s == ST_APPLY);
      cmd_op_r  <= cmd_op_nx_s;
      cmd_idx_r <= cmd_idx_nx_s;
    end
  end

  // Cell decode: flush forces a clear on every cell and drops the pending command
  always_comb begin
    cell_j_s = '0;
    cell_k_s = '0;
    cell_e_s = '0;
    for (int b = 0; b < NBITS; b++) begin
      cell_j_s[b] = _flush ? 1'b0 : cmd_op_r[1];
      cell_k_s[b] = _flush ? 1'b1 : cmd_op_r[0];
      cell_e_s[b] = _flush | ((state_r == ST_APPLY) && !err_r && (cmd_idx_r == IW'(b)));
    end
  end

  for (genvar b = 0; b < NBITS; b++) begin : g_cell
    jk_cell u_cell (
      ._clock (_clock),
      ._reset (_reset),
      ._J     (cell_j_s[b]),
      ._K     (cell_k_s[b]),
      ._E     (cell_e_s[b]),
      ._Q     (_Q[b]),
      ._QNOT  (_QNOT[b])
    );
  end

  assign _gnt  = gnt_r;
  assign _err  = err_r;
  assign _busy = busy_r;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: an 8-cell instance plus a 6-cell one for out-of-range indices.
module tb_jk_bank_arbiter;
  import jk_bank_pkg::*;

  typedef struct packed {
    logic [3:0] gnt;
    logic       err;
    logic [7:0] q;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic [3:0]  req, gnt, req6, gnt6;
  logic [7:0]  op, op6, q, qn;
  logic [11:0] idx, idx6;
  logic        err, busy, err6, busy6;
  logic [5:0]  q6, qn6;

  exp_t       sb[$];
  exp_t       e;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] qm;

  always #5 clk = ~clk;

  jk_bank_arbiter #(.NREQ(4), .NBITS(8)) dut (
    ._clock(clk), ._reset(rst_n), ._req(req), ._op(op), ._idx(idx), ._flush(flush),
    ._gnt(gnt), ._err(err), ._busy(busy), ._Q(q), ._QNOT(qn)
  );

  jk_bank_arbiter #(.NREQ(4), .NBITS(6)) dut6 (
    ._clock(clk), ._reset(rst_n), ._req(req6), ._op(op6), ._idx(idx6), ._flush(flush),
    ._gnt(gnt6), ._err(err6), ._busy(busy6), ._Q(q6), ._QNOT(qn6)
  );

  function automatic logic [7:0] jk_model(input logic [7:0] qi, input logic [1:0] o, input int x);
    logic [7:0] r;
    r = qi;
    case (o)
      OP_SET:  r[x] = 1'b1;
      OP_CLR:  r[x] = 1'b0;
      OP_TGL:  r[x] = ~r[x];
      default: r = qi;
    endcase
    return r;
  endfunction

  task automatic post(input int r, input logic [1:0] o, input logic [2:0] x);
    req[r]         = 1'b1;
    op[2*r +: 2]   = o;
    idx[3*r +: 3]  = x;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    req = '0; op = '0; idx = '0; req6 = '0; op6 = '0; idx6 = '0;
    #12;
    n_cmp++; if (q !== 8'h00)   begin n_bad++; $display("FAIL reset_q got %h want 00", q); end
    n_cmp++; if (gnt !== 4'h0)  begin n_bad++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (err !== 1'b0)  begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    qm = 8'h00;
  endtask

  task automatic test_single();
    int         rid [7] = '{0, 0, 2, 3, 1, 2, 1};
    logic [1:0] ops [7] = '{OP_SET, OP_TGL, OP_SET, OP_TGL, OP_CLR, OP_HOLD, OP_SET};
    int         ixs [7] = '{5, 5, 0, 7, 0, 7, 3};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      post(rid[k], ops[k], 3'(ixs[k]));
      qm = jk_model(qm, ops[k], ixs[k]);
      sb.push_back('{gnt: 4'(1 << rid[k]), err: 1'b0, q: qm});
      step();
      e = sb.pop_front();
      n_cmp++; if (gnt !== e.gnt) begin n_bad++; $display("FAIL single_gnt[%0d] got %b want %b", k, gnt, e.gnt); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy[%0d] got %b want 1", k, busy); end
      req = '0;
      step();
      n_cmp++; if (q !== e.q)     begin n_bad++; $display("FAIL single_q[%0d] got %h want %h", k, q, e.q); end
      n_cmp++; if (qn !== ~e.q)   begin n_bad++; $display("FAIL single_qnot[%0d] got %h want %h", k, qn, ~e.q); end
      n_cmp++; if (gnt !== 4'h0)  begin n_bad++; $display("FAIL single_gnt_drop[%0d] got %b want 0000", k, gnt); end
    end
  endtask

  task automatic test_contention();
    int         cnt [4] = '{0, 0, 0, 0};
    logic [7:0] qexp;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    qm = 8'h00;
    qexp = 8'h00;
    for (int r = 0; r < 4; r++) post(r, OP_TGL, 3'(r));
    for (int k = 0; k < 6; k++) begin
      sb.push_back('{gnt: 4'(1 << (k % 4)), err: 1'b0, q: qexp});
      qexp = jk_model(qexp, OP_TGL, k % 4);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      e = sb.pop_front();
      n_cmp++; if (gnt !== e.gnt) begin n_bad++; $display("FAIL rr_gnt[%0d] got %b want %b", k, gnt, e.gnt); end
      n_cmp++; if (q !== e.q)     begin n_bad++; $display("FAIL rr_q[%0d] got %h want %h", k, q, e.q); end
      for (int r = 0; r < 4; r++) if (k < 4 && gnt[r]) cnt[r]++;
    end
    req = '0;
    for (int r = 0; r < 4; r++) begin
      n_cmp++; if (cnt[r] != 1) begin n_bad++; $display("FAIL rr_fair[%0d] got %0d want 1", r, cnt[r]); end
    end
    step();
    qm = qexp;
    n_cmp++; if (q !== qm)      begin n_bad++; $display("FAIL rr_final_q got %h want %h", q, qm); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rr_idle got %b want 0", busy); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    post(0, OP_SET, 3'd2);
    sb.push_back('{gnt: 4'b0001, err: 1'b0, q: 8'h00});
    step();
    e = sb.pop_front();
    n_cmp++; if (gnt !== e.gnt) begin n_bad++; $display("FAIL flush_gnt got %b want %b", gnt, e.gnt); end
    flush = 1'b1;
    step();
    n_cmp++; if (q !== e.q)     begin n_bad++; $display("FAIL flush_q got %h want %h", q, e.q); end
    n_cmp++; if (gnt !== 4'h0)  begin n_bad++; $display("FAIL flush_no_gnt got %b want 0000", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy got %b want 0", busy); end
    flush = 1'b0;
    qm = jk_model(8'h00, OP_SET, 2);
    sb.push_back('{gnt: 4'b0001, err: 1'b0, q: qm});
    step();
    e = sb.pop_front();
    n_cmp++; if (gnt !== e.gnt) begin n_bad++; $display("FAIL flush_regnt got %b want %b", gnt, e.gnt); end
    n_cmp++; if (q !== 8'h00)   begin n_bad++; $display("FAIL flush_q_hold got %h want 00", q); end
    req = '0;
    step();
    n_cmp++; if (q !== e.q)     begin n_bad++; $display("FAIL flush_q_after got %h want %h", q, e.q); end
  endtask

  task automatic test_out_of_range();
    int         ixs [3] = '{5, 7, 6};
    logic [7:0] q6m;
    q6m = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req6[1] = 1'b1; op6[3:2] = OP_SET; idx6[5:3] = 3'(ixs[k]);
      if (ixs[k] < 6) q6m = jk_model(q6m, OP_SET, ixs[k]);
      sb.push_back('{gnt: 4'b0010, err: (ixs[k] >= 6), q: q6m});
      step();
      e = sb.pop_front();
      n_cmp++; if (gnt6 !== e.gnt) begin n_bad++; $display("FAIL oor_gnt[%0d] got %b want %b", k, gnt6, e.gnt); end
      n_cmp++; if (err6 !== e.err) begin n_bad++; $display("FAIL oor_err[%0d] got %b want %b", k, err6, e.err); end
      req6 = '0;
      step();
      n_cmp++; if (q6 !== e.q[5:0]) begin n_bad++; $display("FAIL oor_q[%0d] got %h want %h", k, q6, e.q[5:0]); end
      n_cmp++; if (err6 !== 1'b0)   begin n_bad++; $display("FAIL oor_err_drop[%0d] got %b want 0", k, err6); end
    end
  endtask

  task automatic test_hold_reset();
    @(negedge clk);
    post(2, OP_HOLD, 3'd2);
    sb.push_back('{gnt: 4'b0100, err: 1'b0, q: qm});
    step();
    e = sb.pop_front();
    n_cmp++; if (gnt !== e.gnt) begin n_bad++; $display("FAIL hold_gnt got %b want %b", gnt, e.gnt); end
    req = '0;
    step();
    n_cmp++; if (q !== e.q)     begin n_bad++; $display("FAIL hold_q got %h want %h", q, e.q); end
    @(negedge clk);
    post(3, OP_SET, 3'd0);
    step();
    n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL rst_pre_gnt got %b want 1000", gnt); end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (q !== 8'h00)   begin n_bad++; $display("FAIL rst_async_q got %h want 00", q); end
    n_cmp++; if (gnt !== 4'h0)  begin n_bad++; $display("FAIL rst_async_gnt got %b want 0000", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_async_busy got %b want 0", busy); end
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++; if (q !== 8'h00)   begin n_bad++; $display("FAIL rst_no_update got %h want 00", q); end
    @(negedge clk);
    for (int r = 0; r < 4; r++) post(r, OP_HOLD, 3'd0);
    sb.push_back('{gnt: 4'b0001, err: 1'b0, q: 8'h00});
    step();
    e = sb.pop_front();
    n_cmp++; if (gnt !== e.gnt) begin n_bad++; $display("FAIL rst_ptr_gnt got %b want %b", gnt, e.gnt); end
    req = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_flush();
    test_out_of_range();
    test_hold_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
